// File: rtl/despachador_bebida_pkg.sv
// +-----------------------------------------------------------------------+
// | despachador_bebida_pkg: shared widths and FSM encoding                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package despachador_bebida_pkg;

  localparam int c_ancho_nibble = 4;
  localparam int c_ancho_bebida = 8;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ESPUMA   = 2'd1,
    EXTRACTO = 2'd2
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/fifo_bebidas.sv
// +-----------------------------------------------------------------------+
// | fifo_bebidas: synchronous drink-word FIFO with combinational head     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module fifo_bebidas
  import despachador_bebida_pkg::*;
#(
  parameter int PROFUNDIDAD = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [c_ancho_bebida-1:0] din,
  output logic [c_ancho_bebida-1:0] dout,
  output logic                      full,
  output logic                      empty
);

  localparam int c_ancho_ptr  = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
  localparam int c_ancho_ocup = $clog2(PROFUNDIDAD + 1);

  logic [c_ancho_bebida-1:0] r_mem [PROFUNDIDAD];
  logic [c_ancho_ptr-1:0]    r_ptr_esc;
  logic [c_ancho_ptr-1:0]    r_ptr_lec;
  logic [c_ancho_ocup-1:0]   r_ocup;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_ptr_esc] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr_esc <= '0;
      r_ptr_lec <= '0;
      r_ocup    <= '0;
    end else begin
      if (push) begin
        r_ptr_esc <= r_ptr_esc + c_ancho_ptr'(1);
      end
      if (pop) begin
        r_ptr_lec <= r_ptr_lec + c_ancho_ptr'(1);
      end
      case ({push, pop})
        2'b10:   r_ocup <= r_ocup + c_ancho_ocup'(1);
        2'b01:   r_ocup <= r_ocup - c_ancho_ocup'(1);
        default: r_ocup <= r_ocup;
      endcase
    end
  end

  assign dout  = r_mem[r_ptr_lec];
  assign full  = (r_ocup == c_ancho_ocup'(PROFUNDIDAD));
  assign empty = (r_ocup == '0);

endmodule

`default_nettype wire

// File: rtl/despachador_bebida.sv
// +-----------------------------------------------------------------------+
// | despachador_bebida: splits drink words into espuma/extracto nibbles   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module despachador_bebida
  import despachador_bebida_pkg::*;
#(
  parameter int PROFUNDIDAD = 2,
  parameter int ANCHO_CONT  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [c_ancho_bebida-1:0] bebida,
  input  logic                      bebida_valid,
  output logic                      bebida_ready,
  output logic [c_ancho_nibble-1:0] nibble,
  output logic                      es_espuma,
  output logic                      nibble_valid,
  input  logic                      nibble_ready,
  output logic [ANCHO_CONT-1:0]     servidas,
  output logic                      ocupado
);

  estado_t                   r_estado;
  estado_t                   w_estado_sig;
  logic [c_ancho_bebida-1:0] r_hold;
  logic [ANCHO_CONT-1:0]     r_servidas;
  logic [c_ancho_bebida-1:0] w_cabeza;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_servir;
  logic                      w_full;
  logic                      w_empty;

  assign w_push = bebida_valid && !w_full;

  fifo_bebidas #(
    .PROFUNDIDAD (PROFUNDIDAD)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bebida),
    .dout  (w_cabeza),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_estado_sig = r_estado;
    w_pop        = 1'b0;
    w_servir     = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_estado_sig = ESPUMA;
        end
      end
      ESPUMA: begin
        if (nibble_ready) begin
          w_estado_sig = EXTRACTO;
        end
      end
      EXTRACTO: begin
        // Reload straight from the FIFO so consecutive drinks leave no bubble.
        if (nibble_ready) begin
          w_servir = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_estado_sig = ESPUMA;
          end else begin
            w_estado_sig = REPOSO;
          end
        end
      end
      default: w_estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= REPOSO;
      r_hold     <= '0;
      r_servidas <= '0;
    end else begin
      r_estado <= w_estado_sig;
      if (w_pop) begin
        r_hold <= w_cabeza;
      end
      if (w_servir) begin
        r_servidas <= r_servidas + ANCHO_CONT'(1);
      end
    end
  end

  always_comb begin
    nibble       = '0;
    es_espuma    = 1'b0;
    nibble_valid = 1'b0;
    case (r_estado)
      ESPUMA: begin
        nibble       = r_hold[c_ancho_bebida-1:c_ancho_nibble];
        es_espuma    = 1'b1;
        nibble_valid = 1'b1;
      end
      EXTRACTO: begin
        nibble       = r_hold[c_ancho_nibble-1:0];
        nibble_valid = 1'b1;
      end
      default: begin
        nibble       = '0;
        es_espuma    = 1'b0;
        nibble_valid = 1'b0;
      end
    endcase
  end

  assign bebida_ready = !w_full;
  assign servidas     = r_servidas;
  assign ocupado      = !w_empty || (r_estado != REPOSO);

endmodule

`default_nettype wire

// File: tb/tb_despachador_bebida.sv
// +-----------------------------------------------------------------------+
// | tb_despachador_bebida: directed scenarios for despachador_bebida      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_despachador_bebida;

  localparam int PROFUNDIDAD = 2;
  localparam int ANCHO_CONT  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [7:0]            bebida = '0;
  logic                  bebida_valid = 1'b0;
  logic                  bebida_ready;
  logic [3:0]            nibble;
  logic                  es_espuma;
  logic                  nibble_valid;
  logic                  nibble_ready = 1'b0;
  logic [ANCHO_CONT-1:0] servidas;
  logic                  ocupado;

  int total = 0;
  int bad   = 0;

  despachador_bebida #(
    .PROFUNDIDAD (PROFUNDIDAD),
    .ANCHO_CONT  (ANCHO_CONT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bebida       (bebida),
    .bebida_valid (bebida_valid),
    .bebida_ready (bebida_ready),
    .nibble       (nibble),
    .es_espuma    (es_espuma),
    .nibble_valid (nibble_valid),
    .nibble_ready (nibble_ready),
    .servidas     (servidas),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  // Leaves the bench on a falling edge with reset just released.
  task automatic aplicar_reset();
    bebida_valid = 1'b0;
    bebida       = '0;
    nibble_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    aplicar_reset();
    bebida_valid = 1'b1;
    bebida       = 8'h77;
    @(negedge clk);
    bebida = 8'h88;
    @(negedge clk);
    bebida = 8'h99;
    @(negedge clk);
    bebida_valid = 1'b0;
    total++;
    if (nibble_valid !== 1'b1 || nibble !== 4'h7) begin
      bad++;
      $display("FAIL reset_prestate: nv=%b nibble=%h want nv=1 nibble=7", nibble_valid, nibble);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (nibble_valid !== 1'b0 || nibble !== 4'h0 || es_espuma !== 1'b0) begin
      bad++;
      $display("FAIL reset_nibble: nv=%b nibble=%h es=%b want 0/0/0", nibble_valid, nibble, es_espuma);
    end
    total++;
    if (servidas !== '0 || ocupado !== 1'b0 || bebida_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_status: servidas=%0d ocupado=%b ready=%b want 0/0/1", servidas, ocupado, bebida_ready);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    nibble_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (nibble_valid !== 1'b0 || ocupado !== 1'b0 || bebida_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_stale: cycle %0d nv=%b ocupado=%b ready=%b want 0/0/1", i, nibble_valid, ocupado, bebida_ready);
      end
    end
  endtask

  task automatic test_single();
    aplicar_reset();
    nibble_ready = 1'b1;
    bebida_valid = 1'b1;
    bebida       = 8'hA5;
    @(negedge clk);
    bebida_valid = 1'b0;
    total++;
    if (nibble_valid !== 1'b0 || ocupado !== 1'b1) begin
      bad++;
      $display("FAIL single_latency: nv=%b ocupado=%b want 0/1", nibble_valid, ocupado);
    end
    @(negedge clk);
    total++;
    if (nibble_valid !== 1'b1 || nibble !== 4'hA || es_espuma !== 1'b1) begin
      bad++;
      $display("FAIL single_espuma: nv=%b nibble=%h es=%b want 1/A/1", nibble_valid, nibble, es_espuma);
    end
    @(negedge clk);
    total++;
    if (nibble_valid !== 1'b1 || nibble !== 4'h5 || es_espuma !== 1'b0) begin
      bad++;
      $display("FAIL single_extracto: nv=%b nibble=%h es=%b want 1/5/0", nibble_valid, nibble, es_espuma);
    end
    @(negedge clk);
    total++;
    if (servidas !== 8'd1 || nibble_valid !== 1'b0 || ocupado !== 1'b0) begin
      bad++;
      $display("FAIL single_done: servidas=%0d nv=%b ocupado=%b want 1/0/0", servidas, nibble_valid, ocupado);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] palabras [3];
    logic [3:0] esperado [6];
    int         i;
    palabras[0] = 8'h12; palabras[1] = 8'h34; palabras[2] = 8'h56;
    for (int j = 0; j < 6; j++) esperado[j] = 4'(j + 1);
    aplicar_reset();
    nibble_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k >= 2 && k <= 7) begin
        i = k - 2;
        total++;
        if (nibble_valid !== 1'b1 || nibble !== esperado[i] || es_espuma !== ((i % 2) == 0)) begin
          bad++;
          $display("FAIL b2b_nibble%0d: nv=%b nibble=%h es=%b want 1/%h/%b", i, nibble_valid, nibble, es_espuma, esperado[i], (i % 2) == 0);
        end
      end
      if (k == 8) begin
        total++;
        if (servidas !== 8'd3 || nibble_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_count: servidas=%0d nv=%b want 3/0", servidas, nibble_valid);
        end
      end
      if (k < 3) begin
        bebida_valid = 1'b1;
        bebida       = palabras[k];
      end else begin
        bebida_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] palabras [4];
    logic [3:0] esperado [8];
    int         enviados;
    int         recibidos;
    logic       acc;
    palabras[0] = 8'hC3; palabras[1] = 8'hD4; palabras[2] = 8'hE5; palabras[3] = 8'hF6;
    for (int j = 0; j < 4; j++) begin
      esperado[2*j]   = palabras[j][7:4];
      esperado[2*j+1] = palabras[j][3:0];
    end
    enviados  = 0;
    recibidos = 0;
    aplicar_reset();
    nibble_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) begin
        total++;
        if (nibble_valid !== 1'b1 || nibble !== 4'hC || es_espuma !== 1'b1) begin
          bad++;
          $display("FAIL bp_stall: cycle %0d nv=%b nibble=%h es=%b want 1/C/1", c, nibble_valid, nibble, es_espuma);
        end
      end
      if (c >= 3) begin
        total++;
        if (bebida_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_full: cycle %0d bebida_ready=%b want 0", c, bebida_ready);
        end
      end
      bebida_valid = (enviados < 4);
      if (enviados < 4) bebida = palabras[enviados];
      acc = bebida_valid && bebida_ready;
      @(negedge clk);
      if (acc) enviados++;
    end
    total++;
    if (enviados !== 3) begin
      bad++;
      $display("FAIL bp_accepted: got %0d words accepted want 3", enviados);
    end
    nibble_ready = 1'b1;
    for (int c = 0; c < 40 && recibidos < 8; c++) begin
      if (nibble_valid) begin
        total++;
        if (nibble !== esperado[recibidos] || es_espuma !== ((recibidos % 2) == 0)) begin
          bad++;
          $display("FAIL bp_order%0d: nibble=%h es=%b want %h/%b", recibidos, nibble, es_espuma, esperado[recibidos], (recibidos % 2) == 0);
        end
        recibidos++;
      end
      bebida_valid = (enviados < 4);
      if (enviados < 4) bebida = palabras[enviados];
      acc = bebida_valid && bebida_ready;
      @(negedge clk);
      if (acc) enviados++;
    end
    bebida_valid = 1'b0;
    total++;
    if (recibidos !== 8 || servidas !== 8'd4) begin
      bad++;
      $display("FAIL bp_drain: received=%0d servidas=%0d want 8/4", recibidos, servidas);
    end
  endtask

  task automatic test_counter_wrap();
    int   enviados;
    int   hs;
    logic chk255;
    logic acc;
    enviados = 0;
    hs       = 0;
    chk255   = 1'b0;
    aplicar_reset();
    nibble_ready = 1'b1;
    for (int c = 0; c < 2000 && hs < 256; c++) begin
      if (hs == 255 && !chk255) begin
        chk255 = 1'b1;
        total++;
        if (servidas !== 8'd255) begin
          bad++;
          $display("FAIL wrap_255: servidas=%0d want 255", servidas);
        end
      end
      if (nibble_valid && !es_espuma) begin
        total++;
        if (nibble !== 4'(hs)) begin
          bad++;
          $display("FAIL wrap_extracto%0d: nibble=%h want %h", hs, nibble, 4'(hs));
        end
        hs++;
      end
      bebida_valid = (enviados < 256);
      bebida       = 8'(enviados);
      acc = bebida_valid && bebida_ready;
      @(negedge clk);
      if (acc) enviados++;
    end
    bebida_valid = 1'b0;
    total++;
    if (hs !== 256 || servidas !== 8'd0 || !chk255) begin
      bad++;
      $display("FAIL wrap_zero: handshakes=%0d servidas=%0d seen255=%b want 256/0/1", hs, servidas, chk255);
    end
  endtask

  task automatic test_reset_extracto();
    aplicar_reset();
    nibble_ready = 1'b0;
    bebida_valid = 1'b1;
    bebida       = 8'h3B;
    @(negedge clk);
    bebida = 8'h4C;
    @(negedge clk);
    bebida_valid = 1'b0;
    nibble_ready = 1'b1;
    @(negedge clk);
    total++;
    if (nibble_valid !== 1'b1 || nibble !== 4'hB || es_espuma !== 1'b0 || ocupado !== 1'b1) begin
      bad++;
      $display("FAIL rx_prestate: nv=%b nibble=%h es=%b ocupado=%b want 1/B/0/1", nibble_valid, nibble, es_espuma, ocupado);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (nibble_valid !== 1'b0 || nibble !== 4'h0 || es_espuma !== 1'b0 || ocupado !== 1'b0) begin
      bad++;
      $display("FAIL rx_clear: nv=%b nibble=%h es=%b ocupado=%b want 0/0/0/0", nibble_valid, nibble, es_espuma, ocupado);
    end
    @(negedge clk);
    total++;
    if (servidas !== '0) begin
      bad++;
      $display("FAIL rx_count: servidas=%0d want 0", servidas);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (nibble_valid !== 1'b0 || servidas !== '0 || bebida_ready !== 1'b1) begin
        bad++;
        $display("FAIL rx_after: cycle %0d nv=%b servidas=%0d ready=%b want 0/0/1", i, nibble_valid, servidas, bebida_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_counter_wrap();
    test_reset_extracto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
